// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg
// Shared constants, types and the per-LED level update rule for the
// led_fader block.
//   NUM_LED    : number of LED channels driven in parallel
//   LEVEL_W    : width of one brightness level
//   LEVEL_MAX  : brightness of a lit LED (constantly on)
//   PWM_SLOTS  : slots per PWM period; level k lights k of these slots
// ----------------------------------------------------------------------------
package led_pkg;

   localparam int NUM_LED   = 8;
   localparam int LEVEL_W   = 4;
   localparam int LEVEL_MAX = 15;
   localparam int PWM_SLOTS = 15;

   typedef logic [LEVEL_W-1:0] level_t;
   typedef logic [LEVEL_W-1:0] slot_t;

   localparam level_t LEVEL_FULL = level_t'(LEVEL_MAX);
   localparam slot_t  SLOT_LAST  = slot_t'(PWM_SLOTS - 1);

   // Next brightness for one LED.  A lit pattern bit always wins, even on a
   // fade tick, so a re-lit LED jumps straight back to full.  With fading
   // disabled a dark bit extinguishes at once, including mid-fade.
   function automatic level_t next_level(input logic   i_pat,
                                         input logic   i_fade_en,
                                         input logic   i_fade_tick,
                                         input level_t i_cur);
      level_t w_nxt;
      if (i_pat)
         w_nxt = LEVEL_FULL;
      else if (!i_fade_en)
         w_nxt = '0;
      else if (i_fade_tick && (i_cur != '0))
         w_nxt = i_cur - level_t'(1);
      else
         w_nxt = i_cur;
      return w_nxt;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// ----------------------------------------------------------------------------
// led_tick_gen
// Free-running divider: counts 0..DIV-1 and pulses TICK for one cycle on the
// terminal count, then wraps.  DIV=1 gives a tick every cycle.  The first
// tick after reset release lands on the DIV-th rising edge.
//   SYSCLK   : system clock, rising edge
//   SYSRST_N : asynchronous active-low reset
//   TICK     : one-cycle pulse every DIV cycles
// ----------------------------------------------------------------------------
module led_tick_gen #(
   parameter int unsigned DIV = 1
) (
   input  logic SYSCLK,
   input  logic SYSRST_N,
   output logic TICK
);

   // Keep the counter at least one bit wide so DIV=1 still elaborates.
   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          w_term;

   assign w_term = (r_cnt == TERM);
   assign TICK   = w_term;

   always_ff @(posedge SYSCLK or negedge SYSRST_N) begin
      if (!SYSRST_N)
         r_cnt <= '0;
      else if (w_term)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CW'(1);
   end

endmodule

// File: rtl/led_fader.sv
// ----------------------------------------------------------------------------
// led_fader
// Turns an 8-bit on/off LED pattern into PWM drive with an optional trailing
// fade: a bit that drops to 0 either goes dark at once or steps its
// brightness down by one level per fade tick until it reaches 0.
//   SYSCLK   : system clock, all logic on rising edge
//   SYSRST_N : asynchronous active-low reset
//   PAT_IN   : LED pattern, bit i drives LED i (synchronous to SYSCLK)
//   FADE_EN  : 1 = trailing fade on falling bits, 0 = immediate off
//   LED      : registered PWM drive, 1 = lit
// Latency: a PAT_IN bit sampled high at edge n lights its LED after edge n+1.
// ----------------------------------------------------------------------------
module led_fader
   import led_pkg::*;
#(
   parameter int unsigned PWM_DIV  = 1250,
   parameter int unsigned FADE_DIV = 1562500
) (
   input  logic               SYSCLK,
   input  logic               SYSRST_N,
   input  logic [NUM_LED-1:0] PAT_IN,
   input  logic               FADE_EN,
   output logic [NUM_LED-1:0] LED
);

   logic                      w_fade_tick;
   logic                      w_pwm_tick;
   logic [NUM_LED-1:0][LEVEL_W-1:0] r_level;
   logic [NUM_LED-1:0][LEVEL_W-1:0] w_level_nxt;
   slot_t                     r_slot;
   logic [NUM_LED-1:0]        r_led;

   led_tick_gen #(.DIV(FADE_DIV)) u_fade_tick (
      .SYSCLK   (SYSCLK),
      .SYSRST_N (SYSRST_N),
      .TICK     (w_fade_tick)
   );

   led_tick_gen #(.DIV(PWM_DIV)) u_pwm_tick (
      .SYSCLK   (SYSCLK),
      .SYSRST_N (SYSRST_N),
      .TICK     (w_pwm_tick)
   );

   // Per-LED level update; channels are fully independent.
   always_comb begin
      w_level_nxt = '0;
      for (int i = 0; i < NUM_LED; i++)
         w_level_nxt[i] = next_level(PAT_IN[i], FADE_EN, w_fade_tick, r_level[i]);
   end

   always_ff @(posedge SYSCLK or negedge SYSRST_N) begin
      if (!SYSRST_N)
         r_level <= '0;
      else
         r_level <= w_level_nxt;
   end

   // PWM slot 0..PWM_SLOTS-1, advanced once per PWM tick.
   always_ff @(posedge SYSCLK or negedge SYSRST_N) begin
      if (!SYSRST_N)
         r_slot <= '0;
      else if (w_pwm_tick)
         r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + slot_t'(1);
   end

   // Output compares registered level against registered slot only, so
   // PAT_IN never reaches LED combinationally.  Level 15 exceeds every slot
   // (always on); level 0 exceeds none (always off).
   always_ff @(posedge SYSCLK or negedge SYSRST_N) begin
      if (!SYSRST_N)
         r_led <= '0;
      else
         for (int i = 0; i < NUM_LED; i++)
            r_led[i] <= (r_level[i] > r_slot);
   end

   assign LED = r_led;

endmodule

// File: tb/tb_led_fader.sv
module tb_led_fader;
   import led_pkg::*;

   localparam int PD = 2;
   localparam int FD = 10;

   logic       SYSCLK   = 1'b0;
   logic       SYSRST_N = 1'b0;
   logic [7:0] PAT_IN   = 8'h00;
   logic       FADE_EN  = 1'b0;
   logic [7:0] LED;

   always #5 SYSCLK = ~SYSCLK;

   led_fader #(.PWM_DIV(PD), .FADE_DIV(FD)) dut (
      .SYSCLK   (SYSCLK),
      .SYSRST_N (SYSRST_N),
      .PAT_IN   (PAT_IN),
      .FADE_EN  (FADE_EN),
      .LED      (LED)
   );

   int checks   = 0;
   int failures = 0;

   // reference model state
   int         m_fc, m_pc, m_s;
   int         m_l [8];
   logic [7:0] m_led;

   typedef struct {
      logic [7:0]      led;
      logic [7:0][3:0] lvl;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic [7:0] pat;
      logic       fen;
      int         cycles;
      logic       chk;
      logic [7:0] exp_led;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fc = 0; m_pc = 0; m_s = 0; m_led = 8'h00;
      for (int i = 0; i < 8; i++) m_l[i] = 0;
   endtask

   // One clock: model predicts from pre-edge inputs, expectation is queued,
   // then popped and compared against the DUT on the falling edge.
   task automatic run_cycle();
      logic       ft, pt;
      int         nl [8];
      logic [7:0] nled;
      exp_t       e;
      ft = (m_fc == FD - 1);
      pt = (m_pc == PD - 1);
      for (int i = 0; i < 8; i++) begin
         nled[i] = (m_l[i] > m_s);
         if (PAT_IN[i])      nl[i] = 15;
         else if (!FADE_EN)  nl[i] = 0;
         else if (ft && m_l[i] > 0) nl[i] = m_l[i] - 1;
         else                nl[i] = m_l[i];
      end
      @(posedge SYSCLK);
      for (int i = 0; i < 8; i++) m_l[i] = nl[i];
      m_led = nled;
      if (pt) m_s = (m_s == 14) ? 0 : m_s + 1;
      m_fc = ft ? 0 : m_fc + 1;
      m_pc = pt ? 0 : m_pc + 1;
      e.led = m_led;
      for (int i = 0; i < 8; i++) e.lvl[i] = 4'(m_l[i]);
      sbq.push_back(e);
      @(negedge SYSCLK);
      e = sbq.pop_front();
      check("led", {24'h0, LED}, {24'h0, e.led});
      check("levels", dut.r_level, e.lvl);
   endtask

   initial begin
      bit found;
      vecs[0] = '{8'h01, 1'b1,   4, 1'b1, 8'h01}; // steady on
      vecs[1] = '{8'h00, 1'b1, 160, 1'b1, 8'h00}; // full fade to dark
      vecs[2] = '{8'h01, 1'b0,   4, 1'b1, 8'h01};
      vecs[3] = '{8'h00, 1'b0,   2, 1'b1, 8'h00}; // immediate off, 2 edges
      vecs[4] = '{8'h01, 1'b1,   3, 1'b0, 8'h00};
      vecs[5] = '{8'h00, 1'b1,  40, 1'b0, 8'h00}; // partway through fade
      vecs[6] = '{8'h00, 1'b0,   2, 1'b1, 8'h00}; // fade disabled mid-fade
      vecs[7] = '{8'hFF, 1'b1,   3, 1'b1, 8'hFF};

      model_reset();
      repeat (3) @(posedge SYSCLK);
      @(negedge SYSCLK);
      check("reset_led", {24'h0, LED}, 32'h0);
      check("reset_levels", dut.r_level, 32'h0);
      SYSRST_N = 1'b1;

      for (int v = 0; v < 8; v++) begin
         PAT_IN  = vecs[v].pat;
         FADE_EN = vecs[v].fen;
         for (int c = 0; c < vecs[v].cycles; c++) run_cycle();
         if (vecs[v].chk)
            check($sformatf("vec%0d_led", v), {24'h0, LED}, {24'h0, vecs[v].exp_led});
      end

      // asynchronous reset mid-run with all LEDs lit
      #1 SYSRST_N = 1'b0;
      #1;
      check("async_reset_led", {24'h0, LED}, 32'h0);
      check("async_reset_levels", dut.r_level, 32'h0);
      model_reset();
      PAT_IN = 8'h00;
      repeat (2) @(posedge SYSCLK);
      @(negedge SYSCLK);
      SYSRST_N = 1'b1;
      for (int c = 0; c < 40; c++) run_cycle();
      check("post_reset_dark", {24'h0, LED}, 32'h0);

      // collision: relight LED3 on a fade-tick cycle while its level is 5
      FADE_EN = 1'b1;
      PAT_IN  = 8'h08;
      run_cycle(); run_cycle();
      PAT_IN = 8'h00;
      found = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (m_l[3] == 5 && m_fc == FD - 1) begin found = 1'b1; break; end
         run_cycle();
      end
      check("collision_reached", {31'h0, found}, 32'h1);
      PAT_IN = 8'h08;
      run_cycle();
      check("collision_level", {28'h0, dut.r_level[3]}, 32'd15);
      run_cycle();
      check("collision_led", {31'h0, LED[3]}, 32'h1);

      // walking pattern with fade
      PAT_IN = 8'h01;
      for (int s = 0; s < 16; s++) begin
         for (int c = 0; c < 40; c++) run_cycle();
         PAT_IN = {PAT_IN[6:0], PAT_IN[7]};
      end
      PAT_IN = 8'h00;
      for (int c = 0; c < 200; c++) run_cycle();
      check("walk_final_dark", {24'h0, LED}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
